// File: rtl/lfsr_counter_display.sv
// lfsr_counter_display: one WIDTH-bit register that runs as a binary up-counter
// or as a Fibonacci LFSR. A prescaler tick advances it. It supports a seed load
// and a deferred mode toggle. The register drives a multiplexed active-low
// 7-segment display (all hex digits) and two mode LEDs.
// Single clock domain; the prescaler tick is an enable, never a clock.
module lfsr_counter_display #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int              PRESCALE  = 24,
  parameter int              SCAN_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 step,
  input  logic                 toggle,
  input  logic                 load,
  input  logic [WIDTH-1:0]     seed,
  output logic [WIDTH-1:0]     value,
  output logic                 mode,
  output logic                 tick,
  output logic [7:0]           seg,
  output logic [WIDTH/4-1:0]   an,
  output logic                 led_count,
  output logic                 led_lfsr
);

  localparam int DIGITS = WIDTH / 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] DIGIT0_SEL = 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_counter_display: WIDTH must be a multiple of 4 in 4..32");
  end

  // Synchroniser stages; index 1 is the settled copy used by the logic.
  logic [1:0]           step_sync;
  logic [1:0]           toggle_sync;
  logic [1:0]           load_sync;
  logic                 toggle_q;
  logic                 toggle_edge;

  logic [PRESCALE-1:0]  pre_cnt;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [IDX_W-1:0]     digit_idx;

  logic                 toggle_pending;
  logic [WIDTH-1:0]     value_nx;
  logic                 mode_nx;
  logic                 pending_nx;

  logic [WIDTH-1:0]     digit_shift;
  logic [3:0]           nibble;

  // Next register value for mode m. The all-zero LFSR state is forced to 1
  // so that the LFSR can never lock up.
  function automatic logic [WIDTH-1:0] adv(input logic m, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (!m) begin
      r = v + 1'b1;
    end else if (v == '0) begin
      r = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = {v[WIDTH-2:0], ^(v & TAPS)};
    end
    return r;
  endfunction

  // Two-flop synchronisers for the asynchronous inputs, plus a toggle history bit for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_sync   <= '0;
      toggle_sync <= '0;
      load_sync   <= '0;
      toggle_q    <= 1'b0;
    end else begin
      step_sync   <= {step_sync[0], step};
      toggle_sync <= {toggle_sync[0], toggle};
      load_sync   <= {load_sync[0], load};
      toggle_q    <= toggle_sync[1];
    end
  end

  assign toggle_edge = toggle_sync[1] & ~toggle_q;

  // Free-running prescaler. The all-ones cycle is the tick, and the counter wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = &pre_cnt;

  // Register, mode and pending-toggle update. Priority is load, then a pending
  // switch on a tick, then a step on a tick. A new toggle edge always re-arms
  // pending, and a load never clears it.
  always_comb begin
    value_nx   = value;
    mode_nx    = mode;
    pending_nx = toggle_pending;
    if (load_sync[1]) begin
      value_nx = seed;
    end else if (tick && toggle_pending) begin
      mode_nx    = ~mode;
      value_nx   = adv(~mode, value);
      pending_nx = 1'b0;
    end else if (tick && step_sync[1]) begin
      value_nx = adv(mode, value);
    end
    if (toggle_edge) begin
      pending_nx = 1'b1;
    end
  end

  // State register for value/mode/pending; the LEDs follow the post-update mode on each tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value          <= '0;
      mode           <= 1'b0;
      toggle_pending <= 1'b0;
      led_count      <= 1'b0;
      led_lfsr       <= 1'b0;
    end else begin
      value          <= value_nx;
      mode           <= mode_nx;
      toggle_pending <= pending_nx;
      if (tick) begin
        led_count <= ~mode_nx;
        led_lfsr  <= mode_nx;
      end
    end
  end

  // Display refresh: the digit index moves on once per scan-counter wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  assign digit_shift = value >> {digit_idx, 2'b00};
  assign nibble      = digit_shift[3:0];

  // Digit enable (one-hot-low) and segment decode {a..g,dp}, active-low, dp off.
  always_comb begin
    an = ~(DIGIT0_SEL << digit_idx);
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      4'hF: seg = 8'h71;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: doc/lfsr_counter_display.md
Name: lfsr_counter_display

Overview:
- Parametrised successor to the team's 4/16-bit counter/LFSR display block.
- One WIDTH-bit register runs either as a binary up-counter or as a Fibonacci LFSR with parametric taps, advanced by an internal prescaler tick.
- Supports a seed load and a lock-up-free LFSR.
- Drives a multiplexed active-low 7-segment display of all WIDTH/4 hex digits plus two mode LEDs.
- Single clock domain; no derived clocks.

Parameters:
- WIDTH, 16, register width; multiple of 4, range 4..32; DIGITS = WIDTH/4.
- TAPS, 16'hB400, WIDTH-bit tap mask; feedback = XOR-reduce(value & TAPS).
- PRESCALE, 24, prescaler width; tick period = 2^PRESCALE clocks.
- SCAN_BITS, 16, refresh counter width; digit period = 2^SCAN_BITS clocks.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- step  in  1  level; when high, value advances once per tick.
- toggle  in  1  rising edge requests a mode switch.
- load  in  1  level; loads seed on the next clock edge.
- seed  in  WIDTH  load value.
- value  out  WIDTH  current register.
- mode  out  1  0 = counter, 1 = LFSR.
- tick  out  1  one-cycle prescaler pulse.
- seg  out  8  active-low segments {a,b,c,d,e,f,g,dp}.
- an  out  DIGITS  active-low digit enables, one-hot-low.
- led_count  out  1  counter-mode indicator.
- led_lfsr  out  1  LFSR-mode indicator.

Behaviour:
- Reset (reset_n low, asynchronous): value=0, mode=0, toggle_pending=0, prescaler=0, scan counter=0, digit index=0, tick=0, led_count=0, led_lfsr=0, an = all ones except bit0 = 0.
- Inputs step, toggle, load are double-flop synchronised: 2-cycle input latency. toggle is edge-detected after synchronisation.
- Prescaler:
  - Free-running PRESCALE-bit up-counter.
  - tick=1 for exactly the one cycle in which the counter equals all-ones; counter then wraps to 0.
- Advance function adv(m, v):
  - m=0: v+1 mod 2^WIDTH (all-ones wraps to 0).
  - m=1: {v[WIDTH-2:0], fb} with fb = ^(v & TAPS).
  - Lock-up: m=1 and v=0 gives result 1.
- Per-clock priority, highest first:
  1. load: value<=seed on the next edge, independent of tick; mode and toggle_pending unchanged; any step or toggle update in that tick is discarded, but a pending toggle stays pending.
  2. tick with toggle_pending: mode<=~mode; value<=adv(~mode, value), i.e. exactly one advance in the new mode regardless of step; pending cleared.
  3. tick with step: value<=adv(mode, value).
  4. Otherwise value holds.
- toggle edge sets toggle_pending. Multiple edges between ticks collapse to one switch. An edge coinciding with a tick that consumes pending re-sets pending (no loss).
- LEDs: updated on each tick from post-update mode: led_count=~mode, led_lfsr=mode. Both stay 0 until the first tick after reset.
- Display:
  - Scan counter free-runs; on its all-ones cycle the digit index advances, wrapping DIGITS-1 -> 0.
  - an[i]=0 only for i = index.
  - seg is a combinational decode of value[4*index+3 : 4*index].
  - Hex codes 0..F: 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71. dp always 1.
  - Digit 0 is the least significant.
- Reset mid-operation: all state returns to reset values immediately; a pending toggle is lost.
- Elaboration: TAPS MSB must be 1 for a maximal-length sequence (not checked). A WIDTH not a multiple of 4 is a fatal elaboration error.

Test Plan:
- Counter wrap (WIDTH=16, PRESCALE=2, step=1): load seed=FFFE, release load -> value FFFF at next tick, then 0000 at the following tick; tick fires every 4 clocks; led_count=1, led_lfsr=0 after the first tick.
- LFSR step: load 0xACE1, pulse toggle, step=1 -> at the first tick mode=1, value=0x59C3; load 0x8000 -> next tick 0x0001; 0x0001 -> 0x0002; led_lfsr=1.
- Lock-up: mode=1, load 0x0000, step=1 -> next tick value=0x0001, never stuck at 0.
- Simultaneous events: three toggle pulses plus load=0x1234 asserted on the tick cycle -> value=0x1234, mode unchanged; next tick flips mode once and advances once in the new mode.
- Display scan (SCAN_BITS=2, value 0x4A7C): an cycles E,D,B,7 every 4 clocks; seg = 63,1F,11,99 respectively.
- Async reset: assert reset_n low mid-count between clock edges -> value=0, mode=0, LEDs 0, an=E immediately without a clock edge; counting restarts from 0001 at the first tick after release.
